// File: rtl/mmc3_pkg.sv
// rtl/mmc3_pkg.sv - shared constants and types for the MMC3 IRQ unit
package mmc3_pkg;

    localparam logic [2:0] REG_IRQ_LATCH  = 3'b100;
    localparam logic [2:0] REG_IRQ_RELOAD = 3'b101;
    localparam logic [2:0] REG_IRQ_DIS    = 3'b110;
    localparam logic [2:0] REG_IRQ_EN     = 3'b111;

    localparam logic [7:0] SST_LATCH   = 8'd0;
    localparam logic [7:0] SST_COUNTER = 8'd1;
    localparam logic [7:0] SST_CTRL    = 8'd2;
    localparam logic [7:0] SST_FILT    = 8'd3;

    typedef enum logic {REV_A, REV_B} irq_rev_t;

endpackage

// File: rtl/mmc3_irq_unit_sync_edge.sv
// rtl/mmc3_irq_unit_sync_edge.sv - multi-flop synchronizer with rise/fall pulses
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = sync_q[STAGES-1] & ~prev_q;
    assign fall  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/mmc3_irq_unit.sv
// rtl/mmc3_irq_unit.sv - MMC3 scanline IRQ: register decode, A12 filter, down-counter
module mmc3_irq_unit
    import mmc3_pkg::*;
#(
    parameter int FILTER_M2   = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] cpu_data,
    input  logic       cpu_a14,
    input  logic       cpu_a13,
    input  logic       cpu_a0,
    input  logic       cpu_ce_n,
    input  logic       cpu_rw,
    input  logic       cpu_m2,
    input  logic       ppu_a12,
    input  logic [3:0] map_sub,
    input  logic [7:0] sst_addr,
    input  logic [7:0] sst_dato,
    input  logic       sst_we,
    output logic [7:0] sst_di,
    output logic       irq_n
);

    localparam int LW = $clog2(FILTER_M2 + 1);
    localparam logic [LW-1:0] FILT_MAX = LW'(FILTER_M2);

    logic          m2_level, m2_rise, m2_fall;
    logic          a12_level, a12_rise, a12_fall;
    logic [7:0]    data_q;
    logic [2:0]    addr_q;
    logic          ce_n_q, rw_q;
    logic [7:0]    latch_q, counter_q;
    logic          reload_q, enable_q, pending_q, defer_q;
    logic [LW-1:0] low_cnt_q;

    logic [7:0]    latch_n, counter_n;
    logic          reload_n, enable_n, pending_n, defer_n;
    logic [LW-1:0] low_cnt_n;
    logic          commit, clk_evt, evt;
    irq_rev_t      rev;
    logic          unused_sig;

    sync_edge #(.STAGES(SYNC_STAGES)) u_m2_sync (
        .clk(clk), .rst(rst), .d(cpu_m2),
        .level(m2_level), .rise(m2_rise), .fall(m2_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES)) u_a12_sync (
        .clk(clk), .rst(rst), .d(ppu_a12),
        .level(a12_level), .rise(a12_rise), .fall(a12_fall)
    );

    assign unused_sig = ^{map_sub[3:1], m2_level, m2_rise, a12_fall};
    assign rev        = map_sub[0] ? REV_A : REV_B;
    assign commit     = m2_fall & ~ce_n_q & ~rw_q;
    assign clk_evt    = a12_rise & (low_cnt_q >= FILT_MAX);
    // An event that collided with a register write is replayed one clk later.
    assign evt        = clk_evt | defer_q;

    always_comb begin
        latch_n   = latch_q;
        counter_n = counter_q;
        reload_n  = reload_q;
        enable_n  = enable_q;
        pending_n = pending_q;
        defer_n   = 1'b0;
        low_cnt_n = low_cnt_q;

        if (a12_level)
            low_cnt_n = '0;
        else if (m2_fall && (low_cnt_q < FILT_MAX))
            low_cnt_n = low_cnt_q + 1'b1;

        if (sst_we) begin
            unique case (sst_addr)
                SST_LATCH:   latch_n = sst_dato;
                SST_COUNTER: counter_n = sst_dato;
                SST_CTRL:    {reload_n, enable_n, pending_n} = sst_dato[2:0];
                SST_FILT:    low_cnt_n = sst_dato[LW-1:0];
                default:     ;
            endcase
        end else if (commit) begin
            defer_n = evt;
            unique case (addr_q)
                REG_IRQ_LATCH:  latch_n = data_q;
                REG_IRQ_RELOAD: begin counter_n = 8'd0; reload_n = 1'b1; end
                REG_IRQ_DIS:    begin enable_n = 1'b0; pending_n = 1'b0; end
                REG_IRQ_EN:     enable_n = 1'b1;
                default:        ;
            endcase
        end else if (evt) begin
            if (counter_q == 8'd0 || reload_q) begin
                counter_n = latch_q;
                reload_n  = 1'b0;
            end else begin
                counter_n = counter_q - 8'd1;
            end
            // Rev A only fires on a transition into zero, never on a stuck-at-zero reload.
            if (counter_n == 8'd0 && enable_q &&
                (rev == REV_B || counter_q != 8'd0 || reload_q))
                pending_n = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q    <= 8'd0;
            addr_q    <= 3'd0;
            ce_n_q    <= 1'b1;
            rw_q      <= 1'b1;
            latch_q   <= 8'd0;
            counter_q <= 8'd0;
            reload_q  <= 1'b0;
            enable_q  <= 1'b0;
            pending_q <= 1'b0;
            defer_q   <= 1'b0;
            low_cnt_q <= '0;
            irq_n     <= 1'b1;
        end else begin
            data_q    <= cpu_data;
            addr_q    <= {cpu_a14, cpu_a13, cpu_a0};
            ce_n_q    <= cpu_ce_n;
            rw_q      <= cpu_rw;
            latch_q   <= latch_n;
            counter_q <= counter_n;
            reload_q  <= reload_n;
            enable_q  <= enable_n;
            pending_q <= pending_n;
            defer_q   <= defer_n;
            low_cnt_q <= low_cnt_n;
            irq_n     <= ~pending_n;
        end
    end

    always_comb begin
        sst_di = 8'hFF;
        unique case (sst_addr)
            SST_LATCH:   sst_di = latch_q;
            SST_COUNTER: sst_di = counter_q;
            SST_CTRL:    sst_di = {5'b0, reload_q, enable_q, pending_q};
            SST_FILT:    sst_di = {{(8-LW){1'b0}}, low_cnt_q};
            default:     sst_di = 8'hFF;
        endcase
    end

endmodule
